// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state and owner encodings shared by the memory arbiter and its winner picker
package mem_arbiter_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational winner select for the memory arbiter.
// ARB_ROUND_ROBIN_EN defined: ties go to the port not served last; undefined: dcache wins every tie.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic rr_last,
  output logic winner
);
`ifdef ARB_ROUND_ROBIN_EN
  assign winner = (i_req && d_req) ? ((rr_last == OWN_D) ? OWN_I : OWN_D) : (d_req ? OWN_D : OWN_I);
`else
  // With no request the output is a don't-care, so rr_last is simply passed through
  assign winner = d_req ? OWN_D : (i_req ? OWN_I : rr_last);
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block memory between icache (read) and dcache (read/write), one transfer at a time.
// Tie policy selected by ARB_ROUND_ROBIN_EN (see arb_pick); default is fixed dcache priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mread,
  output logic              mwrite,
  output logic [ADDR_W-1:0] maddress,
  output logic [DATA_W-1:0] mwritedata,
  input  logic [DATA_W-1:0] mreaddata,
  input  logic              mbusywait
);
  logic [1:0] state_q, state_d;
  logic owner_q, owner_d, seen_q, seen_d, rr_last_q, rr_last_d;
  logic mread_q, mread_d, mwrite_q, mwrite_d;
  logic [ADDR_W-1:0] maddress_q, maddress_d;
  logic [DATA_W-1:0] mwritedata_q, mwritedata_d;
  logic [DATA_W-1:0] i_readdata_q, i_readdata_d, d_readdata_q, d_readdata_d;
  logic i_req, d_req, winner;

  assign i_req = i_read;
  assign d_req = d_read || d_write;

  arb_pick u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .rr_last(rr_last_q),
    .winner (winner)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    seen_d       = seen_q;
    rr_last_d    = rr_last_q;
    mread_d      = mread_q;
    mwrite_d     = mwrite_q;
    maddress_d   = maddress_q;
    mwritedata_d = mwritedata_q;
    i_readdata_d = i_readdata_q;
    d_readdata_d = d_readdata_q;
    if (state_q == IDLE && (i_req || d_req)) begin
      state_d      = GRANT;
      owner_d      = winner;
      seen_d       = 1'b0;
      maddress_d   = (winner == OWN_D) ? d_address : i_address;
      mwritedata_d = (winner == OWN_D) ? d_writedata : mwritedata_q;
      mread_d      = (winner == OWN_D) ? d_read : 1'b1;
      mwrite_d     = (winner == OWN_D) && d_write;
    end else if (state_q == GRANT) begin
      // Completion only counts once memory has actually shown busy
      seen_d = seen_q || mbusywait;
      if (seen_q && !mbusywait) begin
        state_d      = DONE;
        mread_d      = 1'b0;
        mwrite_d     = 1'b0;
        i_readdata_d = (mread_q && owner_q == OWN_I) ? mreaddata : i_readdata_q;
        d_readdata_d = (mread_q && owner_q == OWN_D) ? mreaddata : d_readdata_q;
      end
    end else if (state_q != IDLE) begin
      state_d   = IDLE;
      rr_last_d = owner_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_D;
      seen_q       <= 1'b0;
      rr_last_q    <= OWN_I;
      mread_q      <= 1'b0;
      mwrite_q     <= 1'b0;
      maddress_q   <= '0;
      mwritedata_q <= '0;
      i_readdata_q <= '0;
      d_readdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      seen_q       <= seen_d;
      rr_last_q    <= rr_last_d;
      mread_q      <= mread_d;
      mwrite_q     <= mwrite_d;
      maddress_q   <= maddress_d;
      mwritedata_q <= mwritedata_d;
      i_readdata_q <= i_readdata_d;
      d_readdata_q <= d_readdata_d;
    end
  end

  assign i_busywait = i_req && !(state_q == DONE && owner_q == OWN_I);
  assign d_busywait = d_req && !(state_q == DONE && owner_q == OWN_D);
  assign mread      = mread_q;
  assign mwrite     = mwrite_q;
  assign maddress   = maddress_q;
  assign mwritedata = mwritedata_q;
  assign i_readdata = i_readdata_q;
  assign d_readdata = d_readdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random traffic against a transaction-level model of the arbiter and a latency-varying memory
module tb_mem_arbiter;
  logic clock, reset;
  logic i_read, i_busywait, d_read, d_write, d_busywait;
  logic mread, mwrite, mbusywait;
  logic [5:0] i_address, d_address, maddress;
  logic [31:0] i_readdata, d_readdata, d_writedata, mwritedata, mreaddata;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mread(mread), .mwrite(mwrite), .maddress(maddress), .mwritedata(mwritedata),
    .mreaddata(mreaddata), .mbusywait(mbusywait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory: busy for lat_force cycles (random 1..4 when zero) after a strobe appears
  logic [31:0] mem [64];
  int mcnt, lat_force;
  logic mfin, seeded = 1'b0;
  assign mreaddata = mem[maddress];
  always @(posedge clock) begin
    if (reset) begin
      mbusywait <= 1'b0;
      mfin <= 1'b0;
      if (!seeded) begin
        for (int k = 0; k < 64; k++) mem[k] <= $urandom;
        mem[5] <= 32'hDEADBEEF;
        seeded <= 1'b1;
      end
    end else if (!mbusywait && (mread || mwrite) && !mfin) begin
      mbusywait <= 1'b1;
      mcnt <= (lat_force != 0 ? lat_force : int'($urandom_range(1, 4))) - 1;
    end else if (mbusywait) begin
      if (mcnt == 0) begin
        mbusywait <= 1'b0;
        mfin <= 1'b1;
        if (mwrite) mem[maddress] <= mwritedata;
      end else mcnt <= mcnt - 1;
    end else if (!(mread || mwrite)) mfin <= 1'b0;
  end

  // Transaction-level model: phase of the current transfer as seen at each falling edge
  localparam int P_IDLE = 0, P_XFER = 1, P_DONE = 2, P_GAP = 3;
  int phase;
  logic own, last, exp_r, exp_w, prev_busy, ireq, dreq, done_obs, active;
  logic [5:0] exp_a;
  logic [31:0] exp_wd, exp_ird, exp_drd;
  logic [1:0] grants [$];

  always @(negedge clock) begin
    if (reset) begin
      chk("rst_mread", 32'(mread), 0);
      chk("rst_mwrite", 32'(mwrite), 0);
      phase = P_IDLE; last = 1'b0; prev_busy = 1'b0; exp_ird = 0; exp_drd = 0;
      chk("rst_i_readdata", i_readdata, exp_ird);
      chk("rst_d_readdata", d_readdata, exp_drd);
    end else begin
      ireq = i_read;
      dreq = d_read || d_write;
      done_obs = (phase == P_DONE);
      if (done_obs) begin
        if (exp_r && own) exp_drd = mem[exp_a];
        if (exp_r && !own) exp_ird = mem[exp_a];
        grants.push_back({own, exp_w});
        last = own;
      end
      chk("i_busywait", 32'(i_busywait), 32'(ireq && !(done_obs && !own)));
      chk("d_busywait", 32'(d_busywait), 32'(dreq && !(done_obs && own)));
      chk("i_readdata", i_readdata, exp_ird);
      chk("d_readdata", d_readdata, exp_drd);
      active = 1'b0;
      if (phase == P_IDLE && (ireq || dreq)) begin
`ifdef ARB_ROUND_ROBIN_EN
        own = (ireq && dreq) ? !last : dreq;
`else
        own = dreq;
`endif
        exp_r = own ? d_read : 1'b1;
        exp_w = own && d_write;
        exp_a = own ? d_address : i_address;
        exp_wd = d_writedata;
        phase = P_XFER;
        active = 1'b1;
      end else if (phase == P_XFER) begin
        active = 1'b1;
        if (prev_busy && !mbusywait) phase = P_DONE;
      end else if (phase == P_DONE) phase = P_GAP;
      else if (phase == P_GAP) phase = P_IDLE;
      chk("mread", 32'(mread), 32'(active && exp_r));
      chk("mwrite", 32'(mwrite), 32'(active && exp_w));
      if (active) chk("maddress", 32'(maddress), 32'(exp_a));
      if (active && exp_w) chk("mwritedata", mwritedata, exp_wd);
      prev_busy = mbusywait;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic drain(input int bound);
    for (int n = 0; n < bound && (i_read || d_read || d_write); n++) begin
      tick();
      if (i_read && !i_busywait) i_read = 1'b0;
      if ((d_read || d_write) && !d_busywait) begin
        d_read = 1'b0;
        d_write = 1'b0;
      end
    end
    chk("drain", 32'({i_read, d_read, d_write}), 0);
  endtask

  logic first, last_pre;
  logic [1:0] exp6 [3];
  int op;

  initial begin
    reset = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_writedata = '0; lat_force = 0;
    repeat (3) tick();
    chk("rst_maddress", 32'(maddress), 0);
    chk("rst_mwritedata", mwritedata, 0);
    chk("rst_i_bw", 32'(i_busywait), 0);
    chk("rst_d_bw", 32'(d_busywait), 0);
    reset = 1'b0;
    tick();
    // Reset while memory is busy abandons the transfer; the held request then completes
    d_read = 1'b1; d_address = 6'h10;
    for (int n = 0; n < 50 && !mbusywait; n++) tick();
    chk("rm_busy", 32'(mbusywait), 1);
    reset = 1'b1;
    tick();
    chk("rm_mread", 32'(mread), 0);
    chk("rm_d_readdata", d_readdata, 0);
    reset = 1'b0;
    drain(50);
    chk("rm_refetch", d_readdata, mem[6'h10]);
    // icache read with 4-cycle memory
    lat_force = 4;
    i_read = 1'b1; i_address = 6'h05;
    drain(50);
    chk("t1_i_readdata", i_readdata, 32'hDEADBEEF);
    lat_force = 0;
    // dcache write-back
    d_write = 1'b1; d_address = 6'h2A; d_writedata = 32'h11223344;
    drain(50);
    chk("t2_mem", mem[6'h2A], 32'h11223344);
    chk("t2_d_readdata", d_readdata, mem[6'h10]);
    // Four simultaneous read pairs: grants must alternate
    grants.delete();
    last_pre = last;
`ifdef ARB_ROUND_ROBIN_EN
    first = !last_pre;
`else
    first = 1'b1;
`endif
    repeat (4) begin
      i_read = 1'b1; i_address = 6'($urandom);
      d_read = 1'b1; d_address = 6'($urandom);
      drain(100);
    end
    chk("t5_count", grants.size(), 8);
    for (int k = 0; k < grants.size() && k < 8; k++)
      chk("t5_owner", 32'(grants[k][1]), 32'(first ^ k[0]));
    // Write-back followed by refill of 3F while icache waits
    grants.delete();
    d_write = 1'b1; d_address = 6'h3F; d_writedata = 32'hCAFEF00D;
    tick();
    i_read = 1'b1; i_address = 6'h07;
    for (int n = 0; n < 100 && (i_read || d_read || d_write); n++) begin
      tick();
      if (i_read && !i_busywait) i_read = 1'b0;
      if (d_write && !d_busywait) begin
        d_write = 1'b0;
        d_read = 1'b1;
      end else if (d_read && !d_busywait) d_read = 1'b0;
    end
    chk("t6_drain", 32'({i_read, d_read, d_write}), 0);
`ifdef ARB_ROUND_ROBIN_EN
    exp6 = '{2'd3, 2'd0, 2'd2};
`else
    exp6 = '{2'd3, 2'd2, 2'd0};
`endif
    chk("t6_count", grants.size(), 3);
    for (int k = 0; k < grants.size() && k < 3; k++) chk("t6_order", 32'(grants[k]), 32'(exp6[k]));
    chk("t6_d_readdata", d_readdata, 32'hCAFEF00D);
    // Random traffic
    for (int c = 0; c < 600; c++) begin
      tick();
      if (i_read && !i_busywait) begin
        i_read = 1'($urandom);
        i_address = 6'($urandom);
      end else if (!i_read && $urandom_range(0, 2) == 0) begin
        i_read = 1'b1;
        i_address = 6'($urandom);
      end
      if ((d_read || d_write) && !d_busywait || !(d_read || d_write) && $urandom_range(0, 2) == 0) begin
        op = int'($urandom_range(0, 2));
        d_read = (op == 1);
        d_write = (op == 2);
        d_address = 6'($urandom);
        d_writedata = $urandom;
      end
    end
    drain(100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
